// File: rtl/add_share_ctrl.sv
// rtl/add_share_ctrl.sv - two-requester adder that time-shares one 8-bit carry-lookahead slice
module add_share_ctrl #(
   parameter int NSLICE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req0_valid,
   input  logic [8*NSLICE-1:0] req0_A,
   input  logic [8*NSLICE-1:0] req0_B,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [8*NSLICE-1:0] req1_A,
   input  logic [8*NSLICE-1:0] req1_B,
   output logic                req1_ready,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                res_id,
   output logic [8*NSLICE:0]   res_S,
   output logic                busy
);

   localparam int W  = 8 * NSLICE;
   localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W:0]    r_sum;
   logic          r_id;
   logic          r_last;
   logic          r_carry;
   logic [KW-1:0] r_k;

   logic          w_gnt_any;
   logic          w_gnt_id;
   logic          w_hs;
   logic [7:0]    w_sa;
   logic [7:0]    w_sb;
   logic [7:0]    w_g;
   logic [7:0]    w_p;
   logic [7:0]    w_ssum;
   logic [8:0]    w_c;

   // On a tie the requester that was not served last wins.
   assign w_gnt_any  = req0_valid | req1_valid;
   assign w_gnt_id   = (req0_valid & req1_valid) ? ~r_last : req1_valid;
   assign w_hs       = (r_state == S_IDLE) & w_gnt_any;
   assign req0_ready = w_hs & ~w_gnt_id;
   assign req1_ready = w_hs & w_gnt_id;

   assign res_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign res_id    = r_id;
   assign res_S     = r_sum;

   assign w_sa = 8'(r_a >> {r_k, 3'b000});
   assign w_sb = 8'(r_b >> {r_k, 3'b000});

   always_comb begin
      w_g    = w_sa & w_sb;
      w_p    = w_sa ^ w_sb;
      w_c    = '0;
      w_c[0] = r_carry;
      for (int i = 0; i < 8; i++) begin
         w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      end
      w_ssum = w_p ^ w_c[7:0];
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_hs) w_next = S_ADD;
         S_ADD:  if (r_k == K_LAST) w_next = S_DONE;
         S_DONE: if (res_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_id    <= 1'b0;
         r_last  <= 1'b1;
         r_carry <= 1'b0;
         r_k     <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_a     <= w_gnt_id ? req1_A : req0_A;
                  r_b     <= w_gnt_id ? req1_B : req0_B;
                  r_id    <= w_gnt_id;
                  r_last  <= w_gnt_id;
                  r_carry <= 1'b0;
                  r_k     <= '0;
               end
            end
            S_ADD: begin
               for (int i = 0; i < NSLICE; i++) begin
                  if (r_k == KW'(i)) r_sum[8*i +: 8] <= w_ssum;
               end
               if (r_k == K_LAST) r_sum[W] <= w_c[8];
               r_carry <= w_c[8];
               r_k     <= r_k + KW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_add_share_ctrl.sv
// tb/tb_add_share_ctrl.sv - directed and random checks of add_share_ctrl at NSLICE=4 and NSLICE=1
module tb_add_share_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_A, req0_B, req1_A, req1_B;
   logic        res_valid, res_ready, res_id, busy;
   logic [32:0] res_S;

   logic        d1_req0_valid, d1_req1_valid, d1_req0_ready, d1_req1_ready;
   logic [7:0]  d1_req0_A, d1_req0_B, d1_req1_A, d1_req1_B;
   logic        d1_res_valid, d1_res_ready, d1_res_id, d1_busy;
   logic [8:0]  d1_res_S;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   add_share_ctrl #(.NSLICE(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_A(req0_A), .req0_B(req0_B), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_A(req1_A), .req1_B(req1_B), .req1_ready(req1_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_S(res_S), .busy(busy)
   );

   add_share_ctrl #(.NSLICE(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(d1_req0_valid), .req0_A(d1_req0_A), .req0_B(d1_req0_B), .req0_ready(d1_req0_ready),
      .req1_valid(d1_req1_valid), .req1_A(d1_req1_A), .req1_B(d1_req1_B), .req1_ready(d1_req1_ready),
      .res_valid(d1_res_valid), .res_ready(d1_res_ready), .res_id(d1_res_id), .res_S(d1_res_S),
      .busy(d1_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_res4(output int n);
      n = 0;
      while (!res_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check_eq("res_valid_wait", 64'(n < 20), 64'd1);
   endtask

   // Presents one pair on the chosen requester; assumes res_ready high.
   task automatic op4(input logic id, input logic [31:0] a, input logic [31:0] b,
                      output logic [32:0] s, output logic rid, output int lat);
      int n;
      int t0;
      if (id) begin req1_valid = 1'b1; req1_A = a; req1_B = b; end
      else    begin req0_valid = 1'b1; req0_A = a; req0_B = b; end
      #1;
      n = 0;
      while (!(id ? req1_ready : req0_ready) && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check_eq("grant_wait", 64'(n < 20), 64'd1);
      t0 = cyc;
      @(posedge clk); #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      wait_res4(n);
      lat = cyc - t0;
      s   = res_S;
      rid = res_id;
      @(posedge clk); #1;
   endtask

   task automatic op1(input logic [7:0] a, input logic [7:0] b, output logic [8:0] s, output int lat);
      int n;
      int t0;
      d1_req0_valid = 1'b1; d1_req0_A = a; d1_req0_B = b;
      #1;
      n = 0;
      while (!d1_req0_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check_eq("d1_grant_wait", 64'(n < 20), 64'd1);
      t0 = cyc;
      @(posedge clk); #1;
      d1_req0_valid = 1'b0;
      n = 0;
      while (!d1_res_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check_eq("d1_res_wait", 64'(n < 20), 64'd1);
      lat = cyc - t0;
      s   = d1_res_S;
      @(posedge clk); #1;
   endtask

   logic [31:0] va [4] = '{32'h00000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00FF00FF};
   logic [31:0] vb [4] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h00010001};
   logic [32:0] vs [4] = '{33'h000000000, 33'h080000000, 33'h1FFFFFFFE, 33'h001000100};
   logic [7:0]  wa [4] = '{8'hFF, 8'h80, 8'h12, 8'hFF};
   logic [7:0]  wb [4] = '{8'h01, 8'h80, 8'h34, 8'hFF};
   logic [8:0]  ws [4] = '{9'h100, 9'h100, 9'h046, 9'h1FE};

   initial begin
      logic [32:0] s;
      logic [8:0]  s1;
      logic        rid;
      logic [31:0] ra, rb;
      logic [7:0]  ra1, rb1;
      int          lat, n, last_t, seen;

      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0; req0_A = 0; req0_B = 0; req1_A = 0; req1_B = 0;
      res_ready = 0;
      d1_req0_valid = 0; d1_req1_valid = 0; d1_req0_A = 0; d1_req0_B = 0;
      d1_req1_A = 0; d1_req1_B = 0; d1_res_ready = 1;
      #1;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_res_valid", 64'(res_valid), 64'd0);
      check_eq("rst_res_S", 64'(res_S), 64'd0);
      check_eq("rst_res_id", 64'(res_id), 64'd0);
      check_eq("rst_ready0", 64'(req0_ready), 64'd0);
      do_reset();

      // carry through every slice, latency t+5
      res_ready = 1'b1;
      op4(1'b0, 32'hFFFFFFFF, 32'h00000001, s, rid, lat);
      check_eq("c028_sum", 64'(s), 64'h1_0000_0000);
      check_eq("c028_id", 64'(rid), 64'd0);
      check_eq("c028_lat", 64'(lat), 64'd5);
      check_eq("idle_busy", 64'(busy), 64'd0);
      check_eq("idle_res_valid", 64'(res_valid), 64'd0);
      check_eq("idle_hold_S", 64'(res_S), 64'h1_0000_0000);

      for (int i = 0; i < 4; i++) begin
         op4(1'(i % 2), va[i], vb[i], s, rid, lat);
         check_eq("vec_sum", 64'(s), 64'(vs[i]));
         check_eq("vec_id", 64'(rid), 64'(i % 2));
      end

      // round-robin with both requesters continuously valid
      do_reset();
      req0_valid = 1; req0_A = 32'h12345678; req0_B = 32'h11111111;
      req1_valid = 1; req1_A = 32'h0000FFFF; req1_B = 32'h00000001;
      #1;
      check_eq("tie_ready0", 64'(req0_ready), 64'd1);
      check_eq("tie_ready1", 64'(req1_ready), 64'd0);
      last_t = 0;
      for (int r = 0; r < 4; r++) begin
         wait_res4(n);
         check_eq("rr_id", 64'(res_id), 64'(r % 2));
         check_eq("rr_sum", 64'(res_S), (r % 2) ? 64'h0_0001_0000 : 64'h0_2345_6789);
         if (r > 0) check_eq("rr_gap", 64'(cyc - last_t), 64'd6);
         last_t = cyc;
         if (r == 3) begin req0_valid = 0; req1_valid = 0; end
         @(posedge clk); #1;
      end

      // stall in DONE; operand changes during ADD ignored
      res_ready = 1'b0;
      req1_valid = 1; req1_A = 32'h80000000; req1_B = 32'h80000001;
      #1;
      check_eq("stall_ready1", 64'(req1_ready), 64'd1);
      @(posedge clk); #1;
      req1_A = 32'hFFFFFFFF; req1_B = 32'hFFFFFFFF;
      req0_valid = 1; req0_A = 32'h1; req0_B = 32'h1;
      wait_res4(n);
      check_eq("latched_sum", 64'(res_S), 64'h1_0000_0001);
      check_eq("latched_id", 64'(res_id), 64'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check_eq("stall_valid", 64'(res_valid), 64'd1);
         check_eq("stall_S", 64'(res_S), 64'h1_0000_0001);
         check_eq("stall_id", 64'(res_id), 64'd1);
         check_eq("stall_readies", 64'({req0_ready, req1_ready}), 64'd0);
         check_eq("stall_busy", 64'(busy), 64'd1);
      end
      req0_valid = 0; req1_valid = 0; res_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("release_busy", 64'(busy), 64'd0);
      check_eq("release_valid", 64'(res_valid), 64'd0);

      // reset during slice 2
      req0_valid = 1; req0_A = 32'h01010101; req0_B = 32'h02020202;
      #1;
      check_eq("mid_ready0", 64'(req0_ready), 64'd1);
      @(posedge clk); #1;
      req0_valid = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("mid_partial_S", 64'(res_S[15:0]), 64'h0303);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", 64'(busy), 64'd0);
      check_eq("mid_rst_valid", 64'(res_valid), 64'd0);
      check_eq("mid_rst_S", 64'(res_S), 64'd0);
      check_eq("mid_rst_id", 64'(res_id), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (res_valid) seen++;
      end
      check_eq("mid_no_result", 64'(seen), 64'd0);
      req1_valid = 1; req1_A = 32'h5; req1_B = 32'h6;
      req0_valid = 1; req0_A = 32'hDEADBEEF; req0_B = 32'h21524111;
      #1;
      check_eq("post_rst_tie0", 64'(req0_ready), 64'd1);
      check_eq("post_rst_tie1", 64'(req1_ready), 64'd0);
      op4(1'b0, 32'hDEADBEEF, 32'h21524111, s, rid, lat);
      req1_valid = 0;
      check_eq("post_rst_sum", 64'(s), 64'h1_0000_0000);
      check_eq("post_rst_id", 64'(rid), 64'd0);
      check_eq("post_rst_lat", 64'(lat), 64'd5);

      for (int i = 0; i < 300; i++) begin
         ra = $urandom; rb = $urandom;
         op4(1'(i % 2), ra, rb, s, rid, lat);
         check_eq("rand4_sum", 64'(s), 64'({1'b0, ra}) + 64'({1'b0, rb}));
      end

      // NSLICE=1 instance
      for (int i = 0; i < 4; i++) begin
         op1(wa[i], wb[i], s1, lat);
         check_eq("d1_vec_sum", 64'(s1), 64'(ws[i]));
         check_eq("d1_lat", 64'(lat), 64'd2);
      end
      for (int i = 0; i < 300; i++) begin
         ra1 = 8'($urandom); rb1 = 8'($urandom);
         op1(ra1, rb1, s1, lat);
         check_eq("d1_rand_sum", 64'(s1), 64'({1'b0, ra1}) + 64'({1'b0, rb1}));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
